// File: rtl/gpio_bank.sv
// gpio_bank: parametrised GPIO bank with input sync, debounce, edge flags and level irq
// Ports:
//    clk, reset          clock, asynchronous active-high reset
//    sel[6:0]            1-hot select: OUT, DIR, IN, RISE_EN, FALL_EN, FLAGS, IRQ_EN
//    wstrb, rstrb        write / read strobes qualified by sel
//    wdata, rdata        32-bit bus data; rdata is loaded on rstrb and held
//    pin_in              raw asynchronous pad inputs
//    pin_out, pin_dir    pad output values and output enables (1 = drive)
//    irq                 registered OR of FLAGS & IRQ_EN
module gpio_bank #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 1,
   parameter int DEB_DIV     = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       sel,
   input  logic             wstrb,
   input  logic             rstrb,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] pin_out,
   output logic [WIDTH-1:0] pin_dir,
   output logic             irq
);
   localparam int CW = DEB_DIV > 1 ? $clog2(DEB_DIV) : 1;
   logic [CW-1:0]    pre_q, pre_d;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] h0_q, h0_d, h1_q, h1_d, deb_q, deb_d, deb_prev_q;
   logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d, flags_q, flags_d, irq_en_q, irq_en_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             irq_q, irq_d, tick;
   logic [WIDTH-1:0] sync, wd, eq, set, rd;

   if (WIDTH < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^wdata[31:WIDTH];
   end

   always_comb begin
      sync      = sync_q[SYNC_STAGES-1];
      wd        = wdata[WIDTH-1:0];
      tick      = pre_q == CW'(DEB_DIV - 1);
      pre_d     = tick ? '0 : pre_q + CW'(1);
      h0_d      = tick ? sync : h0_q;
      h1_d      = tick ? h0_q : h1_q;
      // pins whose new sample agrees with both stored samples
      eq        = ~(sync ^ h0_q) & ~(sync ^ h1_q);
      deb_d     = DEBOUNCE == 0 ? sync : tick ? (eq & sync) | (~eq & deb_q) : deb_q;
      out_d     = wstrb & sel[0] ? wd : out_q;
      dir_d     = wstrb & sel[1] ? wd : dir_q;
      rise_en_d = wstrb & sel[3] ? wd : rise_en_q;
      fall_en_d = wstrb & sel[4] ? wd : fall_en_q;
      irq_en_d  = wstrb & sel[6] ? wd : irq_en_q;
      set       = (deb_q & ~deb_prev_q & rise_en_q) | (~deb_q & deb_prev_q & fall_en_q);
      // set is OR-ed after the clear so a same-cycle edge wins
      flags_d   = (flags_q & ~(wstrb & sel[5] ? wd : '0)) | set;
      irq_d     = |(flags_q & irq_en_q);
      rd        = (sel[0] ? out_q : '0) | (sel[1] ? dir_q : '0) | (sel[2] ? deb_q : '0) |
                  (sel[3] ? rise_en_q : '0) | (sel[4] ? fall_en_q : '0) |
                  (sel[5] ? flags_q : '0) | (sel[6] ? irq_en_q : '0);
      rdata_d   = rstrb ? 32'(rd) : rdata_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         pre_q      <= '0;
         h0_q       <= '0;
         h1_q       <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         out_q      <= '0;
         dir_q      <= '0;
         rise_en_q  <= '0;
         fall_en_q  <= '0;
         flags_q    <= '0;
         irq_en_q   <= '0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         sync_q[0] <= pin_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         pre_q      <= pre_d;
         h0_q       <= h0_d;
         h1_q       <= h1_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         out_q      <= out_d;
         dir_q      <= dir_d;
         rise_en_q  <= rise_en_d;
         fall_en_q  <= fall_en_d;
         flags_q    <= flags_d;
         irq_en_q   <= irq_en_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
      end
   end

   assign rdata   = rdata_q;
   assign pin_out = out_q;
   assign pin_dir = dir_q;
   assign irq     = irq_q;
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed self-checking bench for gpio_bank (WIDTH=8, DEB_DIV=4)
module tb_gpio_bank;
   logic        clk = 1'b0, reset, wstrb, rstrb, irq;
   logic [6:0]  sel;
   logic [31:0] wdata, rdata;
   logic [7:0]  pin_in, pin_out, pin_dir;
   int          checks = 0, errors = 0, cyc = 0, k;

   gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(1), .DEB_DIV(4)) dut (
      .clk(clk), .reset(reset), .sel(sel), .wstrb(wstrb), .rstrb(rstrb), .wdata(wdata),
      .rdata(rdata), .pin_in(pin_in), .pin_out(pin_out), .pin_dir(pin_dir), .irq(irq)
   );

   always #5 clk = ~clk;

   // cycles since reset release; debounce ticks land on edges where cyc % 4 == 0
   always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [6:0] s, input logic [31:0] d);
      sel = s; wdata = d; wstrb = 1'b1;
      @(negedge clk);
      wstrb = 1'b0; sel = '0;
   endtask

   task automatic rd(input logic [6:0] s);
      sel = s; rstrb = 1'b1;
      @(negedge clk);
      rstrb = 1'b0; sel = '0;
   endtask

   task automatic align1();
      do @(negedge clk); while (cyc % 4 != 1);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; sel = '0; wstrb = 1'b0; rstrb = 1'b0; wdata = '0; pin_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_rdata", rdata, 0);
      chk("rst_out", pin_out, 0);
      chk("rst_dir", pin_dir, 0);
      chk("rst_irq", irq, 0);
      reset = 1'b0;
      wr(7'h01, 32'hA5);
      wr(7'h02, 32'h0F);
      chk("pin_out", pin_out, 8'hA5);
      chk("pin_dir", pin_dir, 8'h0F);
      rd(7'h01);
      chk("rd_out", rdata, 32'h0000_00A5);
      rd(7'h02);
      chk("rd_dir", rdata, 32'h0000_000F);
      repeat (3) @(negedge clk);
      chk("rd_hold", rdata, 32'h0000_000F);
      wr(7'h04, 32'hFF);
      rd(7'h04);
      chk("in_wr_ignored", rdata, 0);
      wr(7'h03, 32'h3C);
      chk("multi_out", pin_out, 8'h3C);
      chk("multi_dir", pin_dir, 8'h3C);
      wr(7'h00, 32'hFF);
      chk("sel0_noop", pin_out, 8'h3C);
      rd(7'h03);
      chk("rd_or", rdata, 32'h3C);
      sel = 7'h01; wdata = 32'h5A; wstrb = 1'b1; rstrb = 1'b1;
      @(negedge clk);
      sel = '0; wstrb = 1'b0; rstrb = 1'b0;
      chk("rw_prewrite", rdata, 32'h3C);
      chk("rw_newout", pin_out, 8'h5A);
      // debounce: 8-cycle pulse spans only two ticks
      pin_in[3] = 1'b1;
      repeat (8) @(negedge clk);
      pin_in[3] = 1'b0;
      repeat (12) @(negedge clk);
      rd(7'h04);
      chk("deb_reject", rdata, 0);
      pin_in[3] = 1'b1;
      repeat (8) @(negedge clk);
      rd(7'h04);
      chk("deb_early", rdata, 0);
      repeat (16) @(negedge clk);
      rd(7'h04);
      chk("deb_accept", rdata, 32'h08);
      pin_in[3] = 1'b0;
      repeat (20) @(negedge clk);
      rd(7'h04);
      chk("deb_release", rdata, 0);
      // rising edge on pin0: deb rises at edge k+11, flag at k+12, irq at k+13
      wr(7'h08, 32'h01);
      wr(7'h40, 32'h01);
      align1();
      k = cyc;
      pin_in[0] = 1'b1;
      wait_until(k + 10);
      sel = 7'h04; rstrb = 1'b1;
      @(negedge clk);
      chk("edge_in_pre", rdata, 0);
      @(negedge clk);
      chk("edge_in_deb", rdata, 32'h01);
      chk("edge_irq_pre", irq, 0);
      sel = 7'h20;
      @(negedge clk);
      chk("edge_flag", rdata, 32'h01);
      chk("edge_irq", irq, 1);
      rstrb = 1'b0; sel = '0;
      wr(7'h20, 32'h01);
      chk("w1c_irq_lag", irq, 1);
      @(negedge clk);
      chk("w1c_irq", irq, 0);
      rd(7'h20);
      chk("w1c_flags", rdata, 0);
      // falling edge only on pin1, interrupt masked
      wr(7'h08, 32'h00);
      wr(7'h10, 32'h02);
      wr(7'h40, 32'h00);
      pin_in[1] = 1'b1;
      repeat (20) @(negedge clk);
      rd(7'h20);
      chk("fall_rise_ign", rdata, 0);
      pin_in[1] = 1'b0;
      repeat (20) @(negedge clk);
      rd(7'h20);
      chk("fall_flag", rdata, 32'h02);
      chk("fall_irq_mask", irq, 0);
      // flag-set cycle coincides with a W1C of all flags
      wr(7'h08, 32'h04);
      align1();
      k = cyc;
      pin_in[2] = 1'b1;
      wait_until(k + 11);
      sel = 7'h20; wdata = 32'hFF; wstrb = 1'b1;
      @(negedge clk);
      sel = '0; wstrb = 1'b0;
      rd(7'h20);
      chk("set_wins", rdata, 32'h04);
      // async reset with pin0 history part-filled
      pin_in[0] = 1'b0; pin_in[2] = 1'b0;
      repeat (20) @(negedge clk);
      wr(7'h40, 32'h04);
      @(negedge clk);
      chk("irq_pre_rst", irq, 1);
      rd(7'h01);
      chk("rd_pre_rst", rdata, 32'h5A);
      align1();
      pin_in[0] = 1'b1;
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_out", pin_out, 0);
      chk("arst_dir", pin_dir, 0);
      chk("arst_rdata", rdata, 0);
      chk("arst_irq", irq, 0);
      @(negedge clk);
      reset = 1'b0;
      wait_until(11);
      sel = 7'h04; rstrb = 1'b1;
      @(negedge clk);
      chk("post_rst_in_pre", rdata, 0);
      @(negedge clk);
      chk("post_rst_in", rdata, 32'h01);
      rstrb = 1'b0; sel = '0;
      rd(7'h20);
      chk("post_rst_flags", rdata, 0);
      rd(7'h02);
      chk("post_rst_dir", rdata, 0);
      rd(7'h58);
      chk("post_rst_en", rdata, 0);
      chk("post_rst_irq", irq, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
